// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache and its port arbiter
package cache_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == REQ_LS) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// rtl/cache_port_arbiter_rr_pick2.sv - two-way round-robin pick, purely combinational
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick,
  output logic       any
);

  always_comb begin
    pick = req;
    any  = |req;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin sequencer sharing the cache port between fetch and load/store
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hit_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [DATA_W-1:0] cache_wdata_o,
  output logic              cache_rd_o,
  output logic              cache_wr_o,
  input  logic [DATA_W-1:0] cache_rdata_i,
  input  logic              cache_hit_i,
  output logic [CNT_W-1:0]  hit_cnt0_o,
  output logic [CNT_W-1:0]  miss_cnt0_o,
  output logic [CNT_W-1:0]  hit_cnt1_o,
  output logic [CNT_W-1:0]  miss_cnt1_o
);

  arb_state_t state;
  logic       id_q;
  logic       last_q;
  logic [1:0] pick;
  logic       any_req;
  logic       pick_id;
  logic       pick_we;

  rr_pick2 u_pick (
    .req  (req_i),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  assign pick_id = (pick == 2'b10);
  assign pick_we = pick_id ? we_i[1] : we_i[0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      id_q          <= 1'b0;
      last_q        <= 1'b1;
      gnt_o         <= 2'b00;
      done_o        <= 2'b00;
      rdata_o       <= '0;
      hit_o         <= 1'b0;
      cache_addr_o  <= '0;
      cache_wdata_o <= '0;
      cache_rd_o    <= 1'b0;
      cache_wr_o    <= 1'b0;
      hit_cnt0_o    <= '0;
      miss_cnt0_o   <= '0;
      hit_cnt1_o    <= '0;
      miss_cnt1_o   <= '0;
    end else begin
      gnt_o      <= 2'b00;
      done_o     <= 2'b00;
      cache_rd_o <= 1'b0;
      cache_wr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            // Fields are latched here so the requester may move on after its grant.
            id_q          <= pick_id;
            last_q        <= pick_id;
            cache_addr_o  <= pick_id ? addr1_i : addr0_i;
            cache_wdata_o <= pick_id ? wdata1_i : wdata0_i;
            cache_rd_o    <= ~pick_we;
            cache_wr_o    <= pick_we;
            gnt_o         <= pick;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rdata_o <= cache_rdata_i;
          hit_o   <= cache_hit_i;
          done_o  <= id_onehot(id_q);
          if (cache_hit_i) begin
            if (id_q == REQ_LS) hit_cnt1_o <= sat_inc(hit_cnt1_o);
            else                hit_cnt0_o <= sat_inc(hit_cnt0_o);
          end else begin
            if (id_q == REQ_LS) miss_cnt1_o <= sat_inc(miss_cnt1_o);
            else                miss_cnt0_o <= sat_inc(miss_cnt0_o);
          end
          state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter and sequencer placed in front of `cache_memory`. It lets an instruction-fetch port (requester 0) and a load/store port (requester 1) share the cache's single access port. Each access is a single-shot transaction: request, grant, then a one-cycle done pulse carrying the returned data and hit flag. Per-requester hit/miss statistics counters are kept for performance bring-up.

## Interface
- `ADDR_W`, 32, address width (matches cache `addr`)
- `DATA_W`, 32, data width (matches cache `write_data`/`read_data`)
- `CNT_W`, 16, width of each statistics counter
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_i[1:0]`  in  2  per-requester request level
- `we_i[1:0]`  in  2  per-requester write enable (1 = write, 0 = read)
- `addr0_i`, `addr1_i`  in  ADDR_W  per-requester address
- `wdata0_i`, `wdata1_i`  in  DATA_W  per-requester write data
- `gnt_o[1:0]`  out  2  one-hot grant pulse, one cycle
- `done_o[1:0]`  out  2  one-hot completion pulse, one cycle
- `rdata_o`  out  DATA_W  captured cache `read_data`; valid while `done_o` != 0
- `hit_o`  out  1  captured cache `hit`; valid while `done_o` != 0
- `cache_addr_o`  out  ADDR_W  to cache `addr`
- `cache_wdata_o`  out  DATA_W  to cache `write_data`
- `cache_rd_o`, `cache_wr_o`  out  1  to cache `mem_read`/`mem_write`
- `cache_rdata_i`  in  DATA_W  from cache `read_data`
- `cache_hit_i`  in  1  from cache `hit`
- `hit_cnt0_o`, `miss_cnt0_o`, `hit_cnt1_o`, `miss_cnt1_o`  out  CNT_W  statistics

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. No other transitions except reset.
- **IDLE**
  - If any `req_i` bit is high, pick a winner and latch the winner's `we`, `addr` and `wdata` plus its ID. Go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `gnt_o[id]` = 1.
  - Cache address and write data are driven from the latched values.
  - Exactly one of `cache_rd_o`/`cache_wr_o` is high, selected by the latched `we`.
- **WAIT**: strobes low; address and data held. The cache's registered outputs settle.
- **RESP**
  - Capture `cache_rdata_i` and `cache_hit_i` into `rdata_o`/`hit_o` at the WAIT->RESP edge.
  - `done_o[id]` = 1.
  - Update statistics for requester `id`: increment hit count if hit, otherwise miss count. Counters saturate at all-ones and do not wrap.
- **Round-robin**
  - `last` pointer holds the ID of the most recently granted requester.
  - If both requesters are high in IDLE, the grant goes to `~last`. A single requester is granted immediately.
  - `last` updates on entry to ISSUE.
- **Requester rules**
  - Request fields are latched at grant, so the requester may change them after `gnt_o`.
  - `req_i` must drop by the edge that ends the `done_o` cycle. If it is still high in IDLE, it is a new request.
  - Dropping `req_i` after grant does not cancel the transaction.
- **Reset**: synchronous, at any state. FSM returns to IDLE and any in-flight transaction is discarded with no `done_o`. `last` = 1, so requester 0 wins the first tie. Counters are cleared.

## Timing
- Reset values: all outputs are 0, including `gnt_o`, `done_o`, cache strobes, `cache_addr_o`, `cache_wdata_o`, `rdata_o`, `hit_o`, and all counters.
- All outputs are registered; there is no combinational path from inputs to outputs.
- With `req_i` high in IDLE at edge N:
  - `gnt_o` is high during cycle N+1.
  - The cache samples the strobe at edge N+2.
  - `done_o` is high during cycle N+3.
  - The next grant can occur at the earliest in cycle N+5 (IDLE occupies cycle N+4).
- Throughput is one transaction per 4 cycles. With continuous contention, grants strictly alternate.
- Cache contract: registered outputs, valid from the edge that samples the strobe. A strobe is never asserted for more than one cycle per transaction.

## Structure
- `cache_pkg` (shared include/package):
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Default ADDR_W/DATA_W.
  - Requester ID constants REQ_IF=0, REQ_LS=1.
  - Reused by `cache_memory` and its testbenches.
- One sub-module: `rr_pick2`. Inputs are `req[1:0]` and `last`; outputs are a one-hot `pick[1:0]` and `any`. It is purely combinational.
- FSM, field latches and counters live in the top.

## Test plan
- **Single read:** reset, then `req_i`=01, `we_i`=00, `addr0_i`=0x00000040, with the cache preloaded with 0xAABBCCDD at that address -> `gnt_o`=01 one cycle later, `cache_rd_o` pulses once, and `done_o`=01 three cycles after the request with `rdata_o`=0xAABBCCDD, `hit_o`=1, `hit_cnt0_o`=1.
- **Write then read:** requester 1 writes 0x12345678 to 0x00000080, then reads it back -> first `done_o`=10; second `done_o`=10 with `rdata_o`=0x12345678, `hit_o`=1.
- **Contention:** both requesters held high for 4 transactions -> grant sequence 01, 10, 01, 10; each `done_o` is 4 cycles apart.
- **Miss path:** read 0x00001040 with the cache cold -> `hit_o`=0, `miss_cnt0_o`=1, `hit_cnt0_o` unchanged.
- **Reset mid-transaction:** assert `rst` in WAIT -> no `done_o` follows, all outputs are 0 next cycle, and a subsequent tie grants requester 0.
- **Saturation:** build with `CNT_W`=2, then run 5 hits on requester 0 -> `hit_cnt0_o` stops at 3.
